// File: rtl/fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader
// Pops a programmed burst of len_i words from a synchronous FIFO read port and
// presents them on a valid/ready stream, marking the final word with m_last_o.
// The FIFO's one-cycle registered read latency is absorbed by a small circular
// output buffer, so a sink that is always ready receives one word per clock.
//
// Ports
//   clk_i         clock, all state on rising edge
//   rst_i         asynchronous active-low reset
//   start_i       start pulse (honoured only when idle), len_i sampled with it
//   len_i         burst length in words
//   abort_i       abandon the current burst
//   busy_o        burst in progress
//   done_o        one-cycle pulse after the last word is accepted
//   err_o         sticky FIFO error flag (set while busy, cleared by start_i)
//   fifo_rd_en_o  FIFO read enable
//   fifo_rdata_i  FIFO read data (valid the cycle after a read)
//   fifo_empty_i  FIFO empty flag
//   fifo_error_i  FIFO error flag
//   m_valid_o     stream word valid
//   m_ready_i     stream sink ready
//   m_data_o      stream word
//   m_last_o      final word of the burst, qualified by m_valid_o
// ---------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int WIDTH      = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 fifo_rd_en_o,
  input  logic [WIDTH-1:0]     fifo_rdata_i,
  input  logic                 fifo_empty_i,
  input  logic                 fifo_error_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [WIDTH-1:0]     m_data_o,
  output logic                 m_last_o
);

  localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  // Occupancy is one bit wider than the count so count + inflight never overflows.
  localparam logic [PTR_W+1:0] DEPTH_C = (PTR_W + 2)'(OBUF_DEPTH);

  logic [0:0]           state_r;
  logic [LEN_WIDTH-1:0] req_left_r;
  logic [LEN_WIDTH-1:0] acc_left_r;
  logic                 inflight_r;
  logic                 done_r;
  logic                 err_r;

  logic [WIDTH-1:0]     obuf_mem_r [OBUF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [PTR_W:0]       count_r;

  logic                 run_s;
  logic [PTR_W+1:0]     occ_s;
  logic                 rd_en_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 flush_s;
  logic                 last_hs_s;
  logic                 valid_s;

  // Read issue and buffer handshake decode.
  always_comb begin
    run_s     = (state_r == ST_RUN);
    // Words already requested from the FIFO reserve a buffer slot.
    occ_s     = {1'b0, count_r} + {{(PTR_W + 1){1'b0}}, inflight_r};
    rd_en_s   = run_s && !abort_i && !fifo_empty_i &&
                (req_left_r != {LEN_WIDTH{1'b0}}) && (occ_s < DEPTH_C);
    valid_s   = (count_r != {(PTR_W + 1){1'b0}});
    flush_s   = run_s && abort_i;
    // A read issued before an abort is still inflight; its capture is dropped.
    push_s    = inflight_r && run_s && !abort_i;
    pop_s     = valid_s && m_ready_i && !abort_i;
    last_hs_s = pop_s && (acc_left_r == LEN_WIDTH'(1));
  end

  // Burst control: state, request/accept counters, done pulse and sticky error.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= ST_IDLE;
      req_left_r <= {LEN_WIDTH{1'b0}};
      acc_left_r <= {LEN_WIDTH{1'b0}};
      inflight_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      inflight_r <= rd_en_s;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            err_r      <= 1'b0;
            req_left_r <= len_i;
            acc_left_r <= len_i;
            if (len_i == {LEN_WIDTH{1'b0}}) begin
              done_r <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (fifo_error_i) begin
            err_r <= 1'b1;
          end
          if (abort_i) begin
            state_r    <= ST_IDLE;
            req_left_r <= {LEN_WIDTH{1'b0}};
            acc_left_r <= {LEN_WIDTH{1'b0}};
          end else begin
            if (rd_en_s) begin
              req_left_r <= req_left_r - LEN_WIDTH'(1);
            end
            if (pop_s) begin
              acc_left_r <= acc_left_r - LEN_WIDTH'(1);
            end
            if (last_hs_s) begin
              state_r <= ST_IDLE;
              done_r  <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Circular output buffer: capture FIFO data one cycle after each read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        obuf_mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else if (flush_s) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push_s) begin
        obuf_mem_r[wr_ptr_r] <= fifo_rdata_i;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign busy_o       = (state_r == ST_RUN);
  assign done_o       = done_r;
  assign err_o        = err_r;
  assign fifo_rd_en_o = rd_en_s;
  assign m_valid_o    = valid_s;
  assign m_data_o     = obuf_mem_r[rd_ptr_r];
  assign m_last_o     = valid_s && (acc_left_r == LEN_WIDTH'(1));

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] len_i;
  logic        abort_i;
  logic        busy_o, done_o, err_o, fifo_rd_en_o;
  logic [7:0]  fifo_rdata_i;
  logic        fifo_empty_i, fifo_error_i;
  logic        m_valid_o, m_ready_i, m_last_o;
  logic [7:0]  m_data_o;
  logic        tb_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] fifo_q [$];   // behavioural FIFO contents
  logic [8:0] exp_q  [$];   // scoreboard: {last, data}
  int rd_q [$];             // cycles with fifo_rd_en_o
  int hs_q [$];             // cycles with a stream handshake
  int done_q [$];           // cycles with done_o
  int rd_on_empty = 0;

  fifo_burst_reader #(.WIDTH(8), .LEN_WIDTH(16), .OBUF_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
    .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .fifo_rd_en_o(fifo_rd_en_o), .fifo_rdata_i(fifo_rdata_i),
    .fifo_empty_i(fifo_empty_i), .fifo_error_i(fifo_error_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_last_o(m_last_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Behavioural sync FIFO with registered read data.
  assign fifo_empty_i = (fifo_q.size() == 0);
  assign fifo_error_i = tb_err;
  always @(posedge clk_i) begin
    if (fifo_rd_en_o) begin
      if (fifo_q.size() == 0) rd_on_empty <= rd_on_empty + 1;
      else fifo_rdata_i <= fifo_q.pop_front();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: log events and score every accepted stream word.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (fifo_rd_en_o) rd_q.push_back(cyc);
      if (done_o) done_q.push_back(cyc);
      if (m_valid_o && m_ready_i) begin
        hs_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", m_data_o);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("stream_data", {24'h0, m_data_o}, {24'h0, e[7:0]});
          check("stream_last", {31'h0, m_last_o}, {31'h0, e[8]});
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_start(input logic [15:0] l);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    len_i   = l;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int base, input int max);
    for (int i = 0; i < max; i++) begin
      if (done_q.size() > base) break;
      tick(1);
    end
    check("done_seen", done_q.size() - base, 1);
  endtask

  int rb, hb, db;

  initial begin
    rst_i = 1'b0; start_i = 1'b0; len_i = 16'h0; abort_i = 1'b0;
    m_ready_i = 1'b0; tb_err = 1'b0;
    #2;
    check("rst_busy",  {31'h0, busy_o}, 32'h0);
    check("rst_valid", {31'h0, m_valid_o}, 32'h0);
    check("rst_done",  {31'h0, done_o}, 32'h0);
    check("rst_rden",  {31'h0, fifo_rd_en_o}, 32'h0);
    #20 rst_i = 1'b1;
    tick(2);

    // 1: full-rate burst of 5
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'h11 + 8'(i));
    for (int i = 0; i < 5; i++) exp_q.push_back({(i == 4), 8'h11 + 8'(i)});
    m_ready_i = 1'b1;
    rb = rd_q.size(); hb = hs_q.size(); db = done_q.size();
    do_start(16'd5);
    wait_done(db, 40);
    check("t1_rd_count", rd_q.size() - rb, 5);
    check("t1_rd_span",  rd_q[rb+4] - rd_q[rb], 4);
    check("t1_latency",  hs_q[hb] - rd_q[rb], 2);
    check("t1_hs_span",  hs_q[hb+4] - hs_q[hb], 4);
    check("t1_done_lat", done_q[db] - hs_q[hb+4], 1);
    tick(3);

    // 2: sink stalled -> only 4 reads, head word held
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'h11 + 8'(i));
    for (int i = 0; i < 5; i++) exp_q.push_back({(i == 4), 8'h11 + 8'(i)});
    m_ready_i = 1'b0;
    rb = rd_q.size(); hb = hs_q.size(); db = done_q.size();
    do_start(16'd5);
    tick(12);
    check("t2_rd_stall",  rd_q.size() - rb, 4);
    check("t2_valid",     {31'h0, m_valid_o}, 32'h1);
    check("t2_hold_data", {24'h0, m_data_o}, 32'h11);
    check("t2_fifo_left", fifo_q.size(), 1);
    m_ready_i = 1'b1;
    wait_done(db, 40);
    check("t2_rd_count", rd_q.size() - rb, 5);
    check("t2_hs_count", hs_q.size() - hb, 5);
    tick(3);

    // 3: FIFO runs dry mid-burst, then refills; error flag is sticky
    fifo_q.push_back(8'h21); fifo_q.push_back(8'h22);
    exp_q.push_back({1'b0, 8'h21}); exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b0, 8'h23}); exp_q.push_back({1'b1, 8'h24});
    rb = rd_q.size(); hb = hs_q.size(); db = done_q.size();
    do_start(16'd4);
    tick(10);
    check("t3_rd_dry",  rd_q.size() - rb, 2);
    check("t3_busy",    {31'h0, busy_o}, 32'h1);
    check("t3_err_pre", {31'h0, err_o}, 32'h0);
    tb_err = 1'b1; tick(1); tb_err = 1'b0; tick(1);
    check("t3_err_set", {31'h0, err_o}, 32'h1);
    fifo_q.push_back(8'h23); fifo_q.push_back(8'h24);
    wait_done(db, 40);
    check("t3_rd_count", rd_q.size() - rb, 4);
    check("t3_hs_count", hs_q.size() - hb, 4);
    tick(2);
    check("t3_err_sticky", {31'h0, err_o}, 32'h1);

    // 4: zero-length burst
    rb = rd_q.size(); db = done_q.size();
    do_start(16'd0);
    @(negedge clk_i);
    check("t4_done",    {31'h0, done_o}, 32'h1);
    check("t4_busy",    {31'h0, busy_o}, 32'h0);
    check("t4_err_clr", {31'h0, err_o}, 32'h0);
    @(negedge clk_i);
    check("t4_done_pulse", {31'h0, done_o}, 32'h0);
    check("t4_no_rd", rd_q.size() - rb, 0);
    tick(2);

    // 5: abort after 3 accepted, then a normal burst of 2
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h50 + 8'(i));
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 8'h50 + 8'(i)});
    hb = hs_q.size(); db = done_q.size();
    m_ready_i = 1'b1;
    do_start(16'd8);
    for (int i = 0; i < 40; i++) begin
      if (hs_q.size() - hb >= 3) break;
      tick(1);
    end
    check("t5_acc3", hs_q.size() - hb, 3);
    abort_i = 1'b1; m_ready_i = 1'b0;
    tick(1);
    abort_i = 1'b0;
    check("t5_busy",  {31'h0, busy_o}, 32'h0);
    check("t5_valid", {31'h0, m_valid_o}, 32'h0);
    tick(4);
    check("t5_no_done", done_q.size() - db, 0);
    fifo_q.delete();
    fifo_q.push_back(8'h61); fifo_q.push_back(8'h62);
    exp_q.push_back({1'b0, 8'h61}); exp_q.push_back({1'b1, 8'h62});
    hb = hs_q.size();
    m_ready_i = 1'b1;
    do_start(16'd2);
    wait_done(db, 40);
    check("t5_hs_after", hs_q.size() - hb, 2);
    tick(2);

    // 6: asynchronous reset mid-burst
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'h71 + 8'(i));
    m_ready_i = 1'b0;
    do_start(16'd4);
    tick(4);
    check("t6_busy_pre", {31'h0, busy_o}, 32'h1);
    #3 rst_i = 1'b0;
    #1;
    check("t6_busy",  {31'h0, busy_o}, 32'h0);
    check("t6_valid", {31'h0, m_valid_o}, 32'h0);
    check("t6_rden",  {31'h0, fifo_rd_en_o}, 32'h0);
    check("t6_data",  {24'h0, m_data_o}, 32'h0);
    check("t6_last",  {31'h0, m_last_o}, 32'h0);
    tick(2);
    rst_i = 1'b1;
    fifo_q.delete();
    tick(3);
    check("t6_idle", {31'h0, busy_o}, 32'h0);

    check("sb_drained", exp_q.size(), 0);
    check("no_rd_on_empty", rd_on_empty, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
